// File: rtl/decode_queue.sv
// Multi-lane RV32I decode stage. Each lane is decoded statically, set lanes are compacted in
// lane order into a circular queue, and the oldest NOUT entries are presented to dispatch.

package C;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {FU_ALU, FU_BRU, FU_LSU, FU_NONE} fu_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     tinst;
    fu_t             fu;
    logic [3:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_valid;
    logic            rs2_valid;
    logic            rd_valid;
    logic [31:0]     imm;
    logic            use_uimm;
    logic [1:0]      size;
    logic            valid;
  } si_t;
endpackage

module static_decoder (
  input  logic [C::XLEN-1:0] pc,
  input  logic [31:0]        inst,
  output C::si_t             si
);
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'h000};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Unrecognised encodings keep pc/tinst with valid = 0 so the backend can trap on them.
  always_comb begin
    si       = '0;
    si.pc    = pc;
    si.tinst = inst;
    si.fu    = C::FU_NONE;
    si.rs1   = inst[19:15];
    si.rs2   = inst[24:20];
    si.rd    = inst[11:7];
    case (opcode)
      7'h13: begin
        si.fu = C::FU_ALU; si.op = {(f3 == 3'b101) & inst[30], f3};
        si.rs1_valid = 1'b1; si.rd_valid = 1'b1; si.imm = imm_i; si.valid = 1'b1;
      end
      7'h33: begin
        si.fu = C::FU_ALU; si.op = {inst[30], f3};
        si.rs1_valid = 1'b1; si.rs2_valid = 1'b1; si.rd_valid = 1'b1; si.valid = 1'b1;
      end
      7'h37, 7'h17: begin
        si.fu = C::FU_ALU; si.op = (opcode == 7'h17) ? 4'hF : 4'h0;
        si.rd_valid = 1'b1; si.imm = imm_u; si.use_uimm = 1'b1; si.valid = 1'b1;
      end
      7'h6F: begin
        si.fu = C::FU_BRU; si.op = 4'h8; si.rd_valid = 1'b1; si.imm = imm_j; si.valid = 1'b1;
      end
      7'h67: begin
        si.fu = C::FU_BRU; si.op = 4'h9; si.rs1_valid = 1'b1; si.rd_valid = 1'b1;
        si.imm = imm_i; si.valid = (f3 == 3'b000);
      end
      7'h63: begin
        si.fu = C::FU_BRU; si.op = {1'b0, f3}; si.rs1_valid = 1'b1; si.rs2_valid = 1'b1;
        si.imm = imm_b; si.valid = (f3 != 3'b010) && (f3 != 3'b011);
      end
      7'h03: begin
        si.fu = C::FU_LSU; si.op = {1'b0, f3}; si.rs1_valid = 1'b1; si.rd_valid = 1'b1;
        si.imm = imm_i; si.size = f3[1:0];
        si.valid = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      7'h23: begin
        si.fu = C::FU_LSU; si.op = {1'b1, f3}; si.rs1_valid = 1'b1; si.rs2_valid = 1'b1;
        si.imm = imm_s; si.size = f3[1:0]; si.valid = (f3 <= 3'b010);
      end
      default: ;
    endcase
  end
endmodule

module decode_queue #(
  parameter int NIN   = 2,
  parameter int NOUT  = 2,
  parameter int DEPTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NIN-1:0]                   fetch_valid_i,
  input  logic [NIN*C::XLEN-1:0]           fetch_pc_i,
  input  logic [NIN*32-1:0]                fetch_data_i,
  output logic                             fetch_ready_o,
  output logic [NOUT-1:0]                  dec_valid_o,
  output logic [NOUT*$bits(C::si_t)-1:0]   dec_si_o,
  input  logic [$clog2(NOUT+1)-1:0]        dec_pop_i,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);
  localparam int SIW = $bits(C::si_t);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int NW  = $clog2(NIN+1);

  C::si_t          mem [DEPTH];
  C::si_t          lane_si [NIN];
  logic [PW-1:0]   lane_slot [NIN];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, pop_cnt, avail;
  logic [NW-1:0]   push_cnt;
  logic            push_en;

  for (genvar gi = 0; gi < NIN; gi++) begin : g_dec
    static_decoder u_dec (
      .pc   (fetch_pc_i[gi*C::XLEN +: C::XLEN]),
      .inst (fetch_data_i[gi*32 +: 32]),
      .si   (lane_si[gi])
    );
  end

  // Each set lane lands after all lower set lanes, so sparse bundles compact with no holes.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NIN; i++) begin
      lane_slot[i] = wr_ptr_reg + PW'(push_cnt);
      push_cnt     = push_cnt + NW'(fetch_valid_i[i]);
    end
  end

  assign fetch_ready_o = (count_reg <= CW'(DEPTH - NIN));
  assign push_en       = fetch_ready_o & (|fetch_valid_i) & ~flush_i;
  assign pop_cnt       = (CW'(dec_pop_i) > count_reg) ? count_reg : CW'(dec_pop_i);
  assign avail         = (count_reg > CW'(NOUT)) ? CW'(NOUT) : count_reg;
  assign count_o       = count_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + (push_en ? PW'(push_cnt) : PW'(0));
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_cnt);
      count_reg  <= count_reg + (push_en ? CW'(push_cnt) : CW'(0)) - pop_cnt;
    end
  end

  // Payload needs no reset: count gates what is visible.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      for (int i = 0; i < NIN; i++) begin
        if (fetch_valid_i[i]) mem[lane_slot[i]] <= lane_si[i];
      end
    end
  end

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
    assign dec_valid_o[gi]          = (count_reg > CW'(gi));
    assign dec_si_o[gi*SIW +: SIW]  = mem[rd_ptr_reg + PW'(gi)];
  end

  pop_within_presented: assert property (@(posedge clk_i) disable iff (rst_i)
    CW'(dec_pop_i) <= avail);
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: each task drives one scenario and checks the outputs
// against hand-computed values one time unit after the clock edge.

module tb_decode_queue;
  localparam int SIW = $bits(C::si_t);
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] ADD  = 32'h002081B3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       fetch_valid = '0;
  logic [63:0]      fetch_pc = '0;
  logic [63:0]      fetch_data = '0;
  logic             fetch_ready;
  logic [1:0]       dec_valid;
  logic [2*SIW-1:0] dec_si;
  logic [1:0]       dec_pop = '0;
  logic [3:0]       count;
  C::si_t           l0, l1;
  int               checks = 0;
  int               errors = 0;

  assign l0 = dec_si[SIW-1:0];
  assign l1 = dec_si[2*SIW-1:SIW];

  always #5 clk = ~clk;

  decode_queue dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .fetch_valid_i (fetch_valid),
    .fetch_pc_i    (fetch_pc),
    .fetch_data_i  (fetch_data),
    .fetch_ready_o (fetch_ready),
    .dec_valid_o   (dec_valid),
    .dec_si_o      (dec_si),
    .dec_pop_i     (dec_pop),
    .count_o       (count)
  );

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] d0,
                       input logic [31:0] pc1, input logic [31:0] d1,
                       input logic [1:0] pop, input logic fl);
    fetch_valid = v;
    fetch_pc    = {pc1, pc0};
    fetch_data  = {d1, d0};
    dec_pop     = pop;
    flush       = fl;
    @(posedge clk); #1;
    $display("txn valid=%b pc0=%h pc1=%h pop=%0d flush=%b -> count=%0d dec_valid=%b ready=%b",
             v, pc0, pc1, pop, fl, count, dec_valid, fetch_ready);
    fetch_valid = '0;
    dec_pop     = '0;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_valid = 2'b11;
    fetch_data  = {ADD, ADDI};
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL reset_dec_valid got %b want 00", dec_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", fetch_ready); end
    rst = 1'b0;
    fetch_valid = '0;
    @(posedge clk); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", count); end
  endtask

  task automatic test_push_pair();
    fetch_valid = 2'b11;
    fetch_pc    = {32'h1004, 32'h1000};
    fetch_data  = {ADD, ADDI};
    #1;
    checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL no_bypass got %b want 00", dec_valid); end
    drive(2'b11, 32'h1000, ADDI, 32'h1004, ADD, 2'd0, 1'b0);
    checks++; if (dec_valid !== 2'b11) begin errors++; $display("FAIL pair_dec_valid got %b want 11", dec_valid); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL pair_count got %0d want 2", count); end
    checks++; if (l0.imm !== 32'd5) begin errors++; $display("FAIL l0_imm got %0d want 5", l0.imm); end
    checks++; if (l0.rd !== 5'd1) begin errors++; $display("FAIL l0_rd got %0d want 1", l0.rd); end
    checks++; if (l0.rs1_valid !== 1'b1 || l0.rs2_valid !== 1'b0) begin errors++;
      $display("FAIL l0_rs_valid got %b%b want 10", l0.rs1_valid, l0.rs2_valid); end
    checks++; if (l0.valid !== 1'b1 || l0.fu !== C::FU_ALU || l0.pc !== 32'h1000) begin errors++;
      $display("FAIL l0_meta got valid=%b fu=%0d pc=%h want 1/0/1000", l0.valid, l0.fu, l0.pc); end
    checks++; if (l1.rs1 !== 5'd1 || l1.rs2 !== 5'd2 || l1.rd !== 5'd3) begin errors++;
      $display("FAIL l1_regs got rs1=%0d rs2=%0d rd=%0d want 1/2/3", l1.rs1, l1.rs2, l1.rd); end
    checks++; if (l1.pc !== 32'h1004 || l1.rs2_valid !== 1'b1) begin errors++;
      $display("FAIL l1_pc got %h rs2v=%b want 1004/1", l1.pc, l1.rs2_valid); end
    drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    checks++; if (count !== 4'd0 || dec_valid !== 2'b00) begin errors++;
      $display("FAIL pair_drain got count=%0d valid=%b want 0/00", count, dec_valid); end
  endtask

  task automatic test_sparse();
    drive(2'b10, 32'h2000, ADDI, 32'h2004, ADD, 2'd0, 1'b0);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL sparse_count got %0d want 1", count); end
    checks++; if (dec_valid !== 2'b01) begin errors++; $display("FAIL sparse_valid got %b want 01", dec_valid); end
    checks++; if (l0.pc !== 32'h2004 || l0.rd !== 5'd3) begin errors++;
      $display("FAIL sparse_lane0 got pc=%h rd=%0d want 2004/3", l0.pc, l0.rd); end
    drive(2'b00, 0, 0, 0, 0, 2'd1, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL sparse_drain got %0d want 0", count); end
  endtask

  task automatic test_full();
    drive(2'b11, 32'h3000, ADDI, 32'h3004, ADDI, 2'd0, 1'b0);
    drive(2'b11, 32'h3008, ADDI, 32'h300C, ADDI, 2'd0, 1'b0);
    drive(2'b11, 32'h3010, ADDI, 32'h3014, ADDI, 2'd0, 1'b0);
    checks++; if (count !== 4'd6 || fetch_ready !== 1'b1) begin errors++;
      $display("FAIL fill6 got count=%0d ready=%b want 6/1", count, fetch_ready); end
    drive(2'b01, 32'h3018, ADDI, 32'h301C, ADDI, 2'd0, 1'b0);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL fill7_count got %0d want 7", count); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fill7_ready got %b want 0", fetch_ready); end
    drive(2'b11, 32'h3F00, ADD, 32'h3F04, ADD, 2'd0, 1'b0);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL ignored_push got count=%0d want 7", count); end
    drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    checks++; if (count !== 4'd5 || fetch_ready !== 1'b1) begin errors++;
      $display("FAIL full_pop got count=%0d ready=%b want 5/1", count, fetch_ready); end
    checks++; if (l0.pc !== 32'h3008 || l1.pc !== 32'h300C) begin errors++;
      $display("FAIL full_order1 got %h/%h want 3008/300c", l0.pc, l1.pc); end
    drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    checks++; if (l0.pc !== 32'h3010 || l1.pc !== 32'h3014 || count !== 4'd3) begin errors++;
      $display("FAIL full_order2 got %h/%h count=%0d want 3010/3014/3", l0.pc, l1.pc, count); end
    drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    checks++; if (l0.pc !== 32'h3018 || dec_valid !== 2'b01) begin errors++;
      $display("FAIL full_last got pc=%h valid=%b want 3018/01", l0.pc, dec_valid); end
    drive(2'b00, 0, 0, 0, 0, 2'd1, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drain got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    int push_idx = 0;
    int pop_idx  = 0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h5000 + 4*push_idx, ADDI, 32'h5004 + 4*push_idx, ADDI, 2'd0, 1'b0);
      push_idx += 2;
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      checks++; if (l0.pc !== 32'h5000 + 4*pop_idx || l1.pc !== 32'h5004 + 4*pop_idx) begin errors++;
        $display("FAIL wrap_order cyc %0d got %h/%h want %h/%h", cyc, l0.pc, l1.pc,
                 32'h5000 + 4*pop_idx, 32'h5004 + 4*pop_idx); end
      drive(2'b11, 32'h5000 + 4*push_idx, ADDI, 32'h5004 + 4*push_idx, ADDI, 2'd2, 1'b0);
      push_idx += 2;
      pop_idx  += 2;
      checks++; if (count !== 4'd6 || fetch_ready !== 1'b1) begin errors++;
        $display("FAIL wrap_count cyc %0d got count=%0d ready=%b want 6/1", cyc, count, fetch_ready); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (l0.pc !== 32'h5000 + 4*pop_idx) begin errors++;
        $display("FAIL wrap_drain got %h want %h", l0.pc, 32'h5000 + 4*pop_idx); end
      drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
      pop_idx += 2;
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", count); end
  endtask

  task automatic test_illegal();
    drive(2'b11, 32'h4000, ADDI, 32'h4004, 32'h0, 2'd0, 1'b0);
    drive(2'b01, 32'h4008, ADD, 32'h400C, ADDI, 2'd0, 1'b0);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL illegal_count got %0d want 3", count); end
    checks++; if (l0.valid !== 1'b1 || l1.valid !== 1'b0) begin errors++;
      $display("FAIL illegal_valid got %b/%b want 1/0", l0.valid, l1.valid); end
    checks++; if (l1.tinst !== 32'h0 || l1.pc !== 32'h4004) begin errors++;
      $display("FAIL illegal_fields got tinst=%h pc=%h want 0/4004", l1.tinst, l1.pc); end
    drive(2'b00, 0, 0, 0, 0, 2'd1, 1'b0);
    checks++; if (l0.valid !== 1'b0 || l0.pc !== 32'h4004) begin errors++;
      $display("FAIL illegal_head got valid=%b pc=%h want 0/4004", l0.valid, l0.pc); end
    checks++; if (l1.valid !== 1'b1 || l1.pc !== 32'h4008 || l1.rd !== 5'd3) begin errors++;
      $display("FAIL illegal_next got valid=%b pc=%h rd=%0d want 1/4008/3", l1.valid, l1.pc, l1.rd); end
    drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL illegal_drain got %0d want 0", count); end
  endtask

  task automatic test_flush();
    drive(2'b11, 32'h6000, ADDI, 32'h6004, ADDI, 2'd0, 1'b0);
    drive(2'b11, 32'h6008, ADDI, 32'h600C, ADDI, 2'd0, 1'b0);
    drive(2'b01, 32'h6010, ADDI, 32'h6014, ADDI, 2'd0, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL preflush_count got %0d want 5", count); end
    drive(2'b11, 32'h6F00, ADD, 32'h6F04, ADD, 2'd1, 1'b1);
    checks++; if (count !== 4'd0 || dec_valid !== 2'b00) begin errors++;
      $display("FAIL flush got count=%0d valid=%b want 0/00", count, dec_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", fetch_ready); end
    drive(2'b01, 32'h7000, ADD, 32'h7004, ADD, 2'd0, 1'b0);
    checks++; if (count !== 4'd1 || l0.pc !== 32'h7000) begin errors++;
      $display("FAIL postflush got count=%0d pc=%h want 1/7000", count, l0.pc); end
    drive(2'b00, 0, 0, 0, 0, 2'd1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(2'b11, 32'h8000, ADDI, 32'h8004, ADD, 2'd0, 1'b0);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL prereset_count got %0d want 2", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 4'd0 || dec_valid !== 2'b00) begin errors++;
      $display("FAIL async_reset got count=%0d valid=%b want 0/00", count, dec_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b want 1", fetch_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL after_async got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_push_pair();
    test_sparse();
    test_full();
    test_wrap();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
